// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle between instruction fetch, the decode/issue controller and the ALU stage.
// master: the surrounding pipeline; slave: alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  mode;
  logic [4:0]  alucontrol;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rs3;
  logic [31:0] imm;
  logic        multi_cycle;
  logic        illegal;
  logic        busy;

  modport master (
    output instr_valid, instr, iss_ready,
    input  instr_ready, iss_valid, mode, alucontrol, rd, rs1, rs2, rs3, imm,
           multi_cycle, illegal, busy
  );

  modport slave (
    input  instr_valid, instr, iss_ready,
    output instr_ready, iss_valid, mode, alucontrol, rd, rs1, rs2, rs3, imm,
           multi_cycle, illegal, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage ahead of the ALU: decodes R4/R3/R2/I words, holds multi-cycle ops off.
// Define ALU_ISSUE_R4_EN to decode the R4 (0001011) opcode; otherwise it is illegal.
//
// state  | meaning
// S_IDLE | no op pending, ready for an instruction
// S_HOLD | decoded op presented (iss_valid=1), frozen until iss_ready
// S_WAIT | multi-cycle op in the ALU, counter running down
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input logic          clk,
  input logic          reset,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT} state_t;

  // WAIT lasts MUL_LAT-1 cycles, so the counter starts one below that
  localparam logic [3:0] WAIT_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        valid_q, mc_q, illegal_q, busy_q;
  logic [1:0]  mode_q;
  logic [4:0]  ctl_q, rd_q, rs1_q, rs2_q, rs3_q;
  logic [31:0] imm_q;

  logic        d_legal, d_mc;
  logic [1:0]  d_mode;
  logic [4:0]  d_ctl, d_rs3;
  logic [31:0] d_imm;
  logic        ready_int, accept;

  always_comb begin
    d_legal = 1'b0;
    d_mc    = 1'b0;
    d_mode  = 2'b00;
    d_ctl   = 5'b00000;
    d_rs3   = 5'b00000;
    d_imm   = 32'h0;
    case (bus.instr[6:0])
      7'b0110011: begin
        d_mode = 2'b01;
        d_ctl  = bus.instr[31:27];
        case (d_ctl)
          5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
          5'b00111, 5'b11100, 5'b11011, 5'b01001, 5'b01010, 5'b10000, 5'b10001,
          5'b10010, 5'b10011, 5'b10100, 5'b01100, 5'b01101, 5'b11111: d_legal = 1'b1;
          default: d_legal = 1'b0;
        endcase
        d_mc = (d_ctl == 5'b11111);
      end
      7'b0101011: begin
        d_mode = 2'b10;
        d_ctl  = bus.instr[31:27];
        case (d_ctl)
          5'b00000, 5'b00001, 5'b01000, 5'b01001, 5'b01010: d_legal = 1'b1;
          default: d_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        d_mode  = 2'b11;
        d_imm   = {{20{bus.instr[31]}}, bus.instr[31:20]};
        d_legal = 1'b1;
        case (bus.instr[14:12])
          3'b000: d_ctl = 5'b00000;
          3'b010: d_ctl = 5'b00001;
          3'b110: d_ctl = 5'b00010;
          3'b111: d_ctl = 5'b00011;
          3'b100: d_ctl = 5'b00110;
          3'b001: begin
            d_ctl   = 5'b10000;
            d_legal = (bus.instr[31:25] == 7'b0);
          end
          3'b101: d_ctl = bus.instr[30] ? 5'b10011 : 5'b10010;
          default: d_legal = 1'b0;
        endcase
      end
`ifdef ALU_ISSUE_R4_EN
      7'b0001011: begin
        d_mode = 2'b00;
        d_ctl  = {bus.instr[26:25], bus.instr[14:12]};
        d_rs3  = bus.instr[31:27];
        case (d_ctl)
          5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
          5'b00111, 5'b10110, 5'b10101, 5'b11001, 5'b11010, 5'b01001, 5'b01010,
          5'b01100, 5'b01101, 5'b01110, 5'b01111: d_legal = 1'b1;
          default: d_legal = 1'b0;
        endcase
        d_mc = (d_ctl == 5'b01110) || (d_ctl == 5'b01111);
      end
`endif
      default: d_legal = 1'b0;
    endcase
  end

  assign ready_int = !reset &&
                     ((state == S_IDLE) || ((state == S_HOLD) && bus.iss_ready && !mc_q));
  assign accept    = bus.instr_valid && ready_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      valid_q   <= 1'b0;
      mc_q      <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 2'b00;
      ctl_q     <= 5'b0;
      rd_q      <= 5'b0;
      rs1_q     <= 5'b0;
      rs2_q     <= 5'b0;
      rs3_q     <= 5'b0;
      imm_q     <= 32'h0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        S_HOLD: if (bus.iss_ready) begin
          valid_q <= 1'b0;
          if (mc_q && (MUL_LAT > 1)) begin
            state  <= S_WAIT;
            busy_q <= 1'b1;
            cnt    <= WAIT_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: if (cnt == 4'd0) begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
      // a new accept overrides the retire above, giving back-to-back issue
      if (accept) begin
        if (d_legal) begin
          state   <= S_HOLD;
          valid_q <= 1'b1;
          mc_q    <= d_mc;
          mode_q  <= d_mode;
          ctl_q   <= d_ctl;
          rd_q    <= bus.instr[11:7];
          rs1_q   <= bus.instr[19:15];
          rs2_q   <= bus.instr[24:20];
          rs3_q   <= d_rs3;
          imm_q   <= d_imm;
        end else begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  assign bus.instr_ready = ready_int;
  assign bus.iss_valid   = valid_q;
  assign bus.mode        = mode_q;
  assign bus.alucontrol  = ctl_q;
  assign bus.rd          = rd_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rs3         = rs3_q;
  assign bus.imm         = imm_q;
  assign bus.multi_cycle = mc_q;
  assign bus.illegal     = illegal_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Decode-and-issue stage that sits in front of the processor ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes each one into the ALU's `mode`/`alucontrol` pair, register indices and a sign-extended immediate. Decoded operations are presented to the ALU stage through a registered valid/ready output. Multi-cycle ops (mul/mac/msc) are held off with a wait counter, and illegal encodings are detected and dropped.

## Interface
- `MUL_LAT`, 3: ALU cycles consumed by mul/mac/msc; range 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  upstream has an instruction.
- `instr_ready`  out  1  block accepts `instr` this cycle.
- `instr`  in  32  instruction word.
- `iss_valid`  out  1  decoded op is valid.
- `iss_ready`  in  1  ALU stage accepts the op.
- `mode`  out  2  00 R4, 01 R3, 10 R2, 11 I.
- `alucontrol`  out  5  ALU operation code.
- `rd`, `rs1`, `rs2`, `rs3`  out  5 each  register indices.
- `imm`  out  32  sign-extended `instr[31:20]`; 0 for non-I ops.
- `multi_cycle`  out  1  issued op is mul/mac/msc.
- `illegal`  out  1  one-cycle pulse for a dropped illegal instruction.
- `busy`  out  1  high in the WAIT state.

## Operation
- **Field extraction:**
  - `rd`=`[11:7]`, `rs1`=`[19:15]`, `rs2`=`[24:20]`.
  - R4: `rs3`=`[31:27]`, `alucontrol`={`[26:25]`,`[14:12]`}.
  - R3/R2: `alucontrol`=`[31:27]`, `rs3`=0.
- **Opcode `[6:0]`:** 0001011→R4, 0110011→R3, 0101011→R2, 0010011→I. Any other opcode is illegal.
- **Legal R4 codes:** 00000–00111, 10110, 10101, 11001, 11010, 01001, 01010, 01100, 01101, 01110, 01111.
- **Legal R3 codes:** 00000–00111, 11100, 11011, 01001, 01010, 10000–10100, 01100, 01101, 11111.
- **Legal R2 codes:** 00000, 00001, 01000, 01001, 01010.
- **I-type `funct3` mapping:**
  - 000→00000, 010→00001, 110→00010, 111→00011, 100→00110.
  - 001→10000 (`instr[31:25]` must be 0).
  - 101→10010 if `instr[30]`=0, 10011 if `instr[30]`=1.
  - Anything else is illegal.
- **`multi_cycle`:** set for R3 11111 and R4 01110/01111.
- **State machine:**
  - IDLE: no op pending.
  - HOLD: `iss_valid`=1; outputs frozen until `iss_ready`.
  - WAIT: counter counts down MUL_LAT-1 cycles.
- **Transitions:**
  - IDLE + accept of a legal instr → HOLD.
  - IDLE + accept of an illegal instr → IDLE, with `illegal` pulsed.
  - HOLD + `iss_ready`, op not multi-cycle: → HOLD if a legal instr is accepted the same cycle (back-to-back); else → IDLE.
  - HOLD + `iss_ready`, op multi-cycle: → WAIT, or → IDLE directly when MUL_LAT=1.
  - WAIT, counter reaches 0 → IDLE.
- **`instr_ready`** = !reset && (state==IDLE || (state==HOLD && `iss_ready` && !`multi_cycle`)).
- **Reset:** every output is 0, the counter is 0 and the state is IDLE. Reset in HOLD or WAIT discards the pending op with no issue.

## Timing
- Decode latency is 1 cycle: accept at edge N, `iss_valid` plus fields are visible after edge N.
- All outputs are registered; no combinational path from `instr` to the outputs.
- Throughput is 1 op/cycle for single-cycle ops while `iss_ready` stays high.
- After a multi-cycle issue at edge N, `instr_ready` stays low until after edge N+MUL_LAT-1.
- `illegal` is high the cycle after the accept edge, and `iss_valid` stays 0 for that instruction.
- While `iss_valid`=1 and `iss_ready`=0, all decode outputs hold their values.
- `busy` is 1 exactly while in WAIT.

## Configuration
- `ALU_ISSUE_R4_EN` defined: R4 opcode 0001011 decodes as specified.
- `ALU_ISSUE_R4_EN` undefined: 0001011 is illegal, `rs3` is tied to 0, and only mul (R3 11111) is multi-cycle.

## Test plan
- Reset asserted mid-HOLD → next cycle all outputs 0 and `instr_ready`=0; after deassert, `instr_ready`=1.
- `instr`=0xFFB10093 (addi x1,x2,-5), `iss_ready`=1 → one cycle later: `mode`=11, `alucontrol`=00000, `rd`=1, `rs1`=2, `imm`=0xFFFFFFFB.
- `instr`=0xF85201B3 (mul x3,x4,x5) then an addi, MUL_LAT=3 → `multi_cycle`=1; `busy`=1 for 2 cycles; addi accepted 3 cycles after the mul issue.
- `instr`=0x1000002B (R2 code 00010) → `illegal` pulses 1 cycle, `iss_valid` stays 0, next instr accepted the following cycle.
- 4 back-to-back R3 adds with `iss_ready` held low 2 cycles on the 2nd op → outputs frozen, no op lost or duplicated, order preserved.
- R4 mac, `ALU_ISSUE_R4_EN` undefined → `illegal`=1, no issue; with the macro defined → `mode`=00, `alucontrol`=01110, `multi_cycle`=1.
